// File: rtl/sys_bridge_ws.sv
// sys_bridge_ws: CPU-to-device bridge with base/mask decode, wait states, timeout and error responses.
// Define BRIDGE_IRQ_SYNC_EN to pass dev_irq to hwint through two flip-flop stages.
module sys_bridge_ws #(
    parameter int N_DEV = 3,
    parameter logic [N_DEV*32-1:0] DEV_BASE = {32'h7F10, 32'h7F00, 32'h0000},
    parameter logic [N_DEV*32-1:0] DEV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000},
    parameter logic [N_DEV-1:0] WORD_ONLY = 3'b110,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pr_req,
    input  logic [31:0]          pr_addr,
    input  logic [3:0]           pr_byteen,
    input  logic [31:0]          pr_wdata,
    output logic [31:0]          pr_rdata,
    output logic                 pr_err,
    output logic                 pr_stall,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wd,
    output logic [N_DEV-1:0]     dev_sel,
    output logic [N_DEV*4-1:0]   dev_we,
    input  logic [N_DEV*32-1:0]  dev_rdata,
    input  logic [N_DEV-1:0]     dev_ready,
    input  logic [N_DEV-1:0]     dev_irq,
    output logic [N_DEV-1:0]     hwint
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d, addr_q, addr_d, wd_q, wd_d, rd_mux;
    logic err_q, err_d;
    logic [3:0] be_q, be_d;
    logic [N_DEV-1:0] sel_q, sel_d, hit, first;
    logic [N_DEV*4-1:0] we_q, we_d;
    logic found, illegal, ready, timeout;
    always_comb begin
        found = 1'b0;
        rd_mux = '0;
        for (int i = 0; i < N_DEV; i++) begin
            hit[i] = (pr_addr & DEV_MASK[i*32 +: 32]) == DEV_BASE[i*32 +: 32];
            first[i] = hit[i] & ~found;
            found = found | hit[i];
            rd_mux = rd_mux | (dev_rdata[i*32 +: 32] & {32{sel_q[i]}});
        end
        illegal = pr_byteen != 4'h0 && pr_byteen != 4'hF && |(first & WORD_ONLY);
        ready = |(dev_ready & sel_q);
        timeout = cnt_q == 8'(TIMEOUT - 1);
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rdata_d = rdata_q;
        err_d = err_q;
        addr_d = addr_q;
        wd_d = wd_q;
        be_d = be_q;
        sel_d = sel_q;
        we_d = we_q;
        case (state_q)
            IDLE: if (pr_req) begin
                addr_d = pr_addr;
                wd_d = pr_wdata;
                be_d = pr_byteen;
                cnt_d = '0;
                if (found && !illegal) begin
                    state_d = ACCESS;
                    sel_d = first;
                    for (int i = 0; i < N_DEV; i++) we_d[i*4 +: 4] = first[i] ? pr_byteen : 4'h0;
                end else begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d = 1'b1;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // a ready in the timeout cycle still counts as success
                if (ready || timeout) begin
                    state_d = RESP;
                    cnt_d = '0;
                    sel_d = '0;
                    we_d = '0;
                    rdata_d = (ready && be_q == 4'h0) ? rd_mux : '0;
                    err_d = !ready;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
            addr_q <= '0;
            wd_q <= '0;
            be_q <= '0;
            sel_q <= '0;
            we_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
            addr_q <= addr_d;
            wd_q <= wd_d;
            be_q <= be_d;
            sel_q <= sel_d;
            we_q <= we_d;
        end
    end
    assign pr_stall = reset & pr_req & (state_q != RESP);
    assign pr_rdata = rdata_q;
    assign pr_err = err_q;
    assign dev_addr = addr_q;
    assign dev_wd = wd_q;
    assign dev_sel = sel_q;
    assign dev_we = we_q;
`ifdef BRIDGE_IRQ_SYNC_EN
    logic [N_DEV-1:0] irq1_q, irq1_d, irq2_q, irq2_d;
    always_comb begin
        irq1_d = dev_irq;
        irq2_d = irq1_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq1_q <= '0;
            irq2_q <= '0;
        end else begin
            irq1_q <= irq1_d;
            irq2_q <= irq2_d;
        end
    end
    assign hwint = irq2_q;
`else
    assign hwint = dev_irq;
`endif
endmodule

// File: tb/tb_sys_bridge_ws.sv
// tb_sys_bridge_ws: randomized and directed checks of sys_bridge_ws against a transaction-level model.
module tb_sys_bridge_ws;
    localparam int N = 3;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pr_req = 1'b0;
    logic [31:0] pr_addr = '0, pr_wdata = '0, pr_rdata, dev_addr, dev_wd;
    logic [3:0] pr_byteen = '0;
    logic pr_err, pr_stall;
    logic [N-1:0] dev_sel, dev_ready = '0, dev_irq = '0, hwint;
    logic [N*4-1:0] dev_we;
    logic [N*32-1:0] dev_rdata = '0;
    always #5 clk = ~clk;
    sys_bridge_ws #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .pr_req(pr_req), .pr_addr(pr_addr), .pr_byteen(pr_byteen),
        .pr_wdata(pr_wdata), .pr_rdata(pr_rdata), .pr_err(pr_err), .pr_stall(pr_stall),
        .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_sel(dev_sel), .dev_we(dev_we),
        .dev_rdata(dev_rdata), .dev_ready(dev_ready), .dev_irq(dev_irq), .hwint(hwint)
    );
    int checks = 0, errors = 0;
    logic [31:0] base [N] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10};
    logic [31:0] mask [N] = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    logic word_only [N] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] chan_data [N];
    int obs_stall, obs_sel_n;
    logic obs_done, obs_err;
    logic [N-1:0] obs_sel;
    logic [N*4-1:0] obs_we;
    logic [31:0] obs_rdata, obs_addr, obs_wd;
    int exp_stall, exp_sel_n;
    logic exp_err;
    logic [N-1:0] exp_sel;
    logic [N*4-1:0] exp_we;
    logic [31:0] exp_rdata;

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++) if ((a & mask[i]) == base[i]) return i;
        return -1;
    endfunction

    // Expected outcome of one access; w = ACCESS cycles the device waits before ready (-1: never)
    task automatic predict(input logic [31:0] a, input logic [3:0] be, input int w);
        int ch;
        logic ok;
        ch = decode(a);
        exp_sel = '0;
        exp_we = '0;
        exp_rdata = '0;
        exp_err = 1'b1;
        exp_stall = 1;
        exp_sel_n = 0;
        if (ch >= 0) begin
            if (!(be != 4'h0 && be != 4'hF && word_only[ch])) begin
                ok = w >= 0 && w < TO;
                exp_sel[ch] = 1'b1;
                exp_we[ch*4 +: 4] = be;
                exp_err = !ok;
                exp_rdata = (ok && be == 4'h0) ? chan_data[ch] : 32'h0;
                exp_sel_n = ok ? w + 1 : TO;
                exp_stall = exp_sel_n + 1;
            end
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        input int w, input logic [31:0] rd);
        int acc, ch;
        logic [N-1:0] noise;
        @(negedge clk);
        for (int i = 0; i < N; i++) chan_data[i] = $urandom;
        ch = decode(a);
        if (ch >= 0) chan_data[ch] = rd;
        for (int i = 0; i < N; i++) dev_rdata[i*32 +: 32] = chan_data[i];
        pr_req = 1'b1;
        pr_addr = a;
        pr_byteen = be;
        pr_wdata = wd;
        obs_stall = 0;
        obs_sel_n = 0;
        obs_sel = '0;
        obs_we = '0;
        obs_done = 1'b0;
        acc = 0;
        for (int c = 0; c < 40 && !obs_done; c++) begin
            #1;
            if (!pr_stall) begin
                obs_done = 1'b1;
                obs_rdata = pr_rdata;
                obs_err = pr_err;
                obs_addr = dev_addr;
                obs_wd = dev_wd;
            end else begin
                obs_stall++;
                if (dev_sel != '0) begin
                    obs_sel_n++;
                    obs_sel |= dev_sel;
                    obs_we |= dev_we;
                end
                noise = N'($urandom);
                dev_ready = (noise & ~dev_sel) | ((dev_sel != '0 && w >= 0 && acc == w) ? dev_sel : '0);
                if (dev_sel != '0) acc++;
                @(negedge clk);
            end
        end
        pr_req = 1'b0;
        dev_ready = '0;
    endtask

    task automatic test_reset;
        pr_req = 1'b1;
        pr_addr = 32'h7F00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pr_stall !== 1'b0 || dev_sel !== '0 || dev_we !== '0 || pr_rdata !== '0 || pr_err !== 1'b0 ||
            dev_addr !== '0 || dev_wd !== '0 || hwint !== '0) begin
            errors++;
            $display("FAIL reset_values got stall=%b sel=%b we=%h rd=%h err=%b addr=%h wd=%h hw=%b exp all 0",
                     pr_stall, dev_sel, dev_we, pr_rdata, pr_err, dev_addr, dev_wd, hwint);
        end
        @(negedge clk);
        pr_req = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_read_wait;
        xfer(32'h0000_1234, 4'h0, 32'h0, 1, 32'hCAFE_F00D);
        checks++;
        if (obs_stall !== 3 || obs_done !== 1'b1) begin
            errors++;
            $display("FAIL read_wait_stall got %0d done=%b exp 3", obs_stall, obs_done);
        end
        checks++;
        if (obs_rdata !== 32'hCAFE_F00D || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL read_wait_data got %h err=%b exp cafef00d err=0", obs_rdata, obs_err);
        end
    endtask

    task automatic test_unmapped;
        xfer(32'h0000_8000, 4'h0, 32'h0, 0, 32'h1234_5678);
        checks++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_stall !== 1 || obs_sel !== '0) begin
            errors++;
            $display("FAIL unmapped got err=%b rd=%h stall=%0d sel=%b exp err=1 rd=0 stall=1 sel=0",
                     obs_err, obs_rdata, obs_stall, obs_sel);
        end
    endtask

    task automatic test_timer_write;
        xfer(32'h0000_7F04, 4'hF, 32'h10, 0, 32'hDEAD_BEEF);
        checks++;
        if (obs_sel_n !== 1 || obs_sel !== 3'b010 || obs_we !== 12'h0F0) begin
            errors++;
            $display("FAIL timer_write_strobe got n=%0d sel=%b we=%h exp n=1 sel=010 we=0f0",
                     obs_sel_n, obs_sel, obs_we);
        end
        checks++;
        if (obs_err !== 1'b0 || obs_stall !== 2 || obs_wd !== 32'h10 || obs_addr !== 32'h7F04 || obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timer_write_resp got err=%b stall=%0d wd=%h addr=%h rd=%h exp 0 2 10 7f04 0",
                     obs_err, obs_stall, obs_wd, obs_addr, obs_rdata);
        end
    endtask

    task automatic test_partial;
        xfer(32'h0000_7F14, 4'b0011, 32'hFFFF_FFFF, 0, 32'h0);
        checks++;
        if (obs_sel !== '0 || obs_we !== '0 || obs_err !== 1'b1 || obs_stall !== 1) begin
            errors++;
            $display("FAIL partial_word_only got sel=%b we=%h err=%b stall=%0d exp 0 0 1 1",
                     obs_sel, obs_we, obs_err, obs_stall);
        end
    endtask

    task automatic test_tie_and_timeout;
        xfer(32'h0000_7F18, 4'h0, 32'h0, TO - 1, 32'h5A5A_1234);
        checks++;
        if (obs_err !== 1'b0 || obs_rdata !== 32'h5A5A_1234 || obs_stall !== TO + 1) begin
            errors++;
            $display("FAIL ready_at_timeout got err=%b rd=%h stall=%0d exp 0 5a5a1234 %0d",
                     obs_err, obs_rdata, obs_stall, TO + 1);
        end
        xfer(32'h0000_7F10, 4'h0, 32'h0, -1, 32'h7777_7777);
        checks++;
        if (obs_sel_n !== TO || obs_sel !== 3'b100 || obs_stall !== TO + 1) begin
            errors++;
            $display("FAIL timeout_sel got n=%0d sel=%b stall=%0d exp %0d 100 %0d",
                     obs_sel_n, obs_sel, obs_stall, TO, TO + 1);
        end
        checks++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp got err=%b rd=%h exp err=1 rd=0", obs_err, obs_rdata);
        end
    endtask

    task automatic test_reset_abort;
        logic bad;
        @(negedge clk);
        pr_req = 1'b1;
        pr_addr = 32'h0000_7F10;
        pr_byteen = 4'h0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dev_sel !== 3'b100 || pr_stall !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got sel=%b stall=%b exp 100 1", dev_sel, pr_stall);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (pr_stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_stall_in_reset got %b exp 0", pr_stall);
        end
        @(negedge clk);
        checks++;
        if (dev_sel !== '0 || dev_we !== '0 || pr_stall !== 1'b0 || pr_err !== 1'b0 || pr_rdata !== '0) begin
            errors++;
            $display("FAIL abort_after_edge got sel=%b we=%h stall=%b err=%b rd=%h exp all 0",
                     dev_sel, dev_we, pr_stall, pr_err, pr_rdata);
        end
        reset = 1'b1;
        pr_req = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dev_sel !== '0 || pr_err !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_resp got activity=%b exp 0", bad);
        end
        xfer(32'h0000_7F00, 4'h0, 32'h0, 0, 32'h0BAD_F00D);
        checks++;
        if (obs_stall !== 2 || obs_rdata !== 32'h0BAD_F00D || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_then_read got stall=%0d rd=%h err=%b exp 2 0badf00d 0",
                     obs_stall, obs_rdata, obs_err);
        end
    endtask

    task automatic test_hold;
        logic [31:0] r;
        logic e;
        xfer(32'h0000_0100, 4'h0, 32'h0, 2, 32'h1357_9BDF);
        r = obs_rdata;
        e = obs_err;
        repeat (4) begin
            @(negedge clk);
            dev_rdata = {N{32'hFFFF_FFFF}};
            dev_ready = N'($urandom);
        end
        #1;
        checks++;
        if (pr_rdata !== 32'h1357_9BDF || r !== 32'h1357_9BDF || pr_err !== 1'b0 || e !== 1'b0) begin
            errors++;
            $display("FAIL hold_outputs got rd=%h err=%b exp 13579bdf 0", pr_rdata, pr_err);
        end
        dev_ready = '0;
    endtask

    task automatic test_irq;
        logic [N-1:0] hist [40];
        logic [N-1:0] exp;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            hist[k] = (k < 6) ? ((k % 2 == 1) ? 3'b010 : 3'b000) : N'($urandom);
            dev_irq = hist[k];
            #1;
`ifdef BRIDGE_IRQ_SYNC_EN
            exp = (k >= 2) ? hist[k-2] : hwint;
`else
            exp = hist[k];
`endif
            if (k >= 2) begin
                checks++;
                if (hwint !== exp) begin
                    errors++;
                    $display("FAIL irq_path step %0d got %b exp %b", k, hwint, exp);
                end
            end
        end
        dev_irq = '0;
    endtask

    task automatic test_random;
        logic [31:0] a, wd;
        logic [3:0] be;
        int w, r;
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 4);
            a = r == 0 ? ($urandom & 32'h3FFF) : r == 1 ? (32'h7F00 | ($urandom & 32'hF)) :
                r == 2 ? (32'h7F10 | ($urandom & 32'hF)) : r == 3 ? (32'h8000 + ($urandom & 32'hFFF)) : $urandom;
            r = $urandom_range(0, 3);
            be = r == 0 ? 4'h0 : r == 1 ? 4'hF : 4'($urandom);
            w = $urandom_range(0, 6) - 1;
            wd = $urandom;
            xfer(a, be, wd, w, $urandom);
            predict(a, be, w);
            checks++;
            if (obs_done !== 1'b1 || obs_stall !== exp_stall) begin
                errors++;
                $display("FAIL rand_latency txn %0d a=%h be=%h w=%0d got %0d done=%b exp %0d",
                         t, a, be, w, obs_stall, obs_done, exp_stall);
            end
            checks++;
            if (obs_sel_n !== exp_sel_n || obs_sel !== exp_sel || obs_we !== exp_we) begin
                errors++;
                $display("FAIL rand_strobe txn %0d a=%h be=%h got n=%0d sel=%b we=%h exp n=%0d sel=%b we=%h",
                         t, a, be, obs_sel_n, obs_sel, obs_we, exp_sel_n, exp_sel, exp_we);
            end
            checks++;
            if (obs_rdata !== exp_rdata || obs_err !== exp_err) begin
                errors++;
                $display("FAIL rand_resp txn %0d a=%h be=%h w=%0d got rd=%h err=%b exp rd=%h err=%b",
                         t, a, be, w, obs_rdata, obs_err, exp_rdata, exp_err);
            end
            checks++;
            if (obs_addr !== a || obs_wd !== wd) begin
                errors++;
                $display("FAIL rand_latch txn %0d got addr=%h wd=%h exp addr=%h wd=%h", t, obs_addr, obs_wd, a, wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_unmapped();
        test_timer_write();
        test_partial();
        test_tie_and_timeout();
        test_reset_abort();
        test_hold();
        test_irq();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
